// File: rtl/ps2_host_tx_pkg.sv
//------------------------------------------------------------------------------
// Module      : ps2_host_tx_pkg
// Description : Shared types, frame constants and helpers for the PS/2 host
//               transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_host_tx_pkg;

    // Full wire frame is start + 8 data + parity + stop; the start bit is
    // driven directly, so the shift register holds one bit less.
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 1;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    // Ceiling log2, never less than 1 so that counters always have a bit.
    function automatic int ps2_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Shift-out order is LSB first: data[0..7], odd parity, stop.
    function automatic logic [PS2_SHIFT_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
//------------------------------------------------------------------------------
// Module      : ps2_line_sync
// Description : Two-stage synchronizer, consecutive-sample glitch filter and
//               registered falling-edge strobe for one PS/2 line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_line_sync
    import ps2_host_tx_pkg::*;
#(
    parameter int FILTER = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    localparam int              c_fcnt_w = ps2_clog2(FILTER);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FILTER - 1);

    logic [1:0]          r_sync;
    logic                r_filt;
    logic                r_fall;
    logic [c_fcnt_w-1:0] r_fcnt;

    // An idle PS/2 bus floats high, so everything resets to 1.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync <= 2'b11;
            r_filt <= 1'b1;
            r_fcnt <= '0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], line_in};
            r_fall <= 1'b0;
            if (r_sync[1] == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_fcnt_last) begin
                r_filt <= r_sync[1];
                r_fcnt <= '0;
                r_fall <= r_filt;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign line_sync = r_sync[1];
    assign fall      = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter sharing the open-drain
//               clock/data pins with the receive-only keyboard port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_KHZ    = 52000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 16000,
    parameter int FILTER     = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_inh_cyc = CLK_KHZ * INHIBIT_US / 1000;
    localparam int c_to_cyc  = CLK_KHZ * TIMEOUT_US / 1000;
    localparam int c_cnt_max = (c_inh_cyc > c_to_cyc) ? c_inh_cyc : c_to_cyc;
    localparam int c_cnt_w   = ps2_clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(c_inh_cyc - 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(c_to_cyc - 1);
    localparam logic [3:0]         c_stop_idx = 4'(PS2_SHIFT_BITS - 1);

    logic                      w_clk_sync;
    logic                      w_clk_fall;
    logic [1:0]                r_data_sync;

    ps2_tx_state_t             r_state;
    logic [PS2_SHIFT_BITS-1:0] r_sh;
    logic [3:0]                r_bitcnt;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_ok;
    logic                      r_clk_oe;
    logic                      r_data_oe;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;

    ps2_line_sync #(
        .FILTER    (FILTER)
    ) u_clk_sync (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .line_in   (ps2clk_in),
        .line_sync (w_clk_sync),
        .fall      (w_clk_fall)
    );

    // Data is only sampled mid-bit on a filtered clock edge, so plain
    // synchronization is enough.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_data_sync <= 2'b11;
        end else begin
            r_data_sync <= {r_data_sync[0], ps2data_in};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sh      <= '1;
            r_bitcnt  <= '0;
            r_cnt     <= '0;
            r_ok      <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    if (tx_valid && r_ready) begin
                        r_sh     <= ps2_frame(tx_data);
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_ok     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_clk_oe <= 1'b1;
                        r_state  <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_cnt == c_inh_last) begin
                        r_cnt     <= '0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_state   <= ST_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_REQ, ST_DATA, ST_ACK, ST_WAIT_IDLE: begin
                    // Timeout wins over any coincident device clock edge.
                    if (r_cnt == c_to_last) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        case (r_state)
                            ST_REQ: begin
                                if (w_clk_fall) begin
                                    r_data_oe <= ~r_sh[0];
                                    r_sh      <= {1'b0, r_sh[PS2_SHIFT_BITS-1:1]};
                                    r_bitcnt  <= 4'd1;
                                    r_state   <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (w_clk_fall) begin
                                    r_sh     <= {1'b0, r_sh[PS2_SHIFT_BITS-1:1]};
                                    r_bitcnt <= r_bitcnt + 1'b1;
                                    if (r_bitcnt == c_stop_idx) begin
                                        r_data_oe <= 1'b0;
                                        r_state   <= ST_ACK;
                                    end else begin
                                        r_data_oe <= ~r_sh[0];
                                    end
                                end
                            end
                            ST_ACK: begin
                                if (w_clk_fall) begin
                                    r_ok    <= ~r_data_sync[1];
                                    r_state <= ST_WAIT_IDLE;
                                end
                            end
                            default: begin
                                // Bus must return to idle before the result
                                // is reported, so the receiver resumes cleanly.
                                if (w_clk_sync && r_data_sync[1]) begin
                                    r_done  <= r_ok;
                                    r_error <= ~r_ok;
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2clk_oe  = r_clk_oe;
    assign ps2data_oe = r_data_oe;
    assign tx_ready   = r_ready;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign tx_error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a behavioural PS/2
//               device model on the open-drain lines.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_host_tx;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_oe, ps2data_oe;
    logic       tx_ready, tx_busy, tx_done, tx_error;

    // Open-drain wired-AND of host and device.
    assign ps2clk_in  = !(ps2clk_oe  || dev_clk_low);
    assign ps2data_in = !(ps2data_oe || dev_data_low);

    always #5 clk_sys = ~clk_sys;

    ps2_host_tx #(
        .CLK_KHZ    (1000),
        .INHIBIT_US (120),
        .TIMEOUT_US (2000),
        .FILTER     (4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    typedef struct {
        logic [7:0] data;
        bit         nack;
        bit         glitch;
        bit         poke;
        bit         exp_parity;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int n_done = 0;
    int n_err = 0;
    int busy_gap = 0;
    bit mon_busy = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference frame from the protocol rules: data LSB first, odd parity, stop.
    function automatic logic [9:0] model_frame(input int d);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = ((d / (1 << i)) % 2) != 0;
            ones += (d / (1 << i)) % 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic tick();
        @(negedge clk_sys);
        if (tx_done)  n_done++;
        if (tx_error) n_err++;
        if (tx_done || tx_error) mon_busy = 1'b0;
        else if (mon_busy && !tx_busy) busy_gap++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_inhibit(output int cnt);
        cnt = 0;
        while (ps2clk_oe && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    task automatic run_xfer(input vec_t v);
        logic [9:0] exp_f;
        logic [9:0] samp;
        int cnt;
        exp_f = model_frame(int'(v.data));
        samp = '0;
        n_done = 0;
        n_err = 0;
        busy_gap = 0;
        start_tx(v.data);
        mon_busy = 1'b1;
        check("accept_clk_low", ps2clk_oe, 1);
        wait_inhibit(cnt);
        check("inhibit_len", cnt, 120);
        check("start_bit", ps2data_oe, 1);
        ticks(30);
        for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            if (v.poke && k == 4) begin
                ticks(20);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick();
                tx_valid = 1'b0;
                ticks(39);
            end else begin
                ticks(60);
            end
            dev_clk_low = 1'b0;
            samp[k] = ps2data_in;
            if (v.glitch) begin
                ticks(25);
                dev_clk_low = 1'b1;
                ticks(2);
                dev_clk_low = 1'b0;
                ticks(33);
            end else begin
                ticks(60);
            end
        end
        if (!v.nack) dev_data_low = 1'b1;
        ticks(20);
        dev_clk_low = 1'b1;
        ticks(60);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        cnt = 0;
        while (n_done + n_err == 0 && cnt < 300) begin
            tick();
            cnt++;
        end
        check("pulse_seen", n_done + n_err, 1);
        check("ready_during_pulse", tx_ready, 0);
        tick();
        check("ready_after_pulse", tx_ready, 1);
        ticks(20);
        check("frame_bits", samp, exp_f);
        check("parity_bit", samp[8], v.exp_parity);
        check("done_count", n_done, v.exp_done);
        check("error_count", n_err, v.exp_err);
        check("busy_held", busy_gap, 0);
        check("lines_released", {ps2clk_oe, ps2data_oe}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        logic [9:0] f;
        int cnt;
        int t;

        tbl[0] = '{8'hED, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 5; i < 11; i++) begin
            tbl[i].data   = 8'($urandom_range(0, 255));
            tbl[i].nack   = ($urandom_range(0, 3) == 0);
            tbl[i].glitch = $urandom_range(0, 1) != 0;
            tbl[i].poke   = $urandom_range(0, 1) != 0;
            f = model_frame(int'(tbl[i].data));
            tbl[i].exp_parity = f[8];
            tbl[i].exp_done   = !tbl[i].nack;
            tbl[i].exp_err    = tbl[i].nack;
        end

        ticks(3);
        check("rst_clk_oe", ps2clk_oe, 0);
        check("rst_data_oe", ps2data_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        reset = 1'b0;
        ticks(5);

        for (int i = 0; i < 11; i++) begin
            run_xfer(tbl[i]);
            ticks(10);
        end

        // Device never answers the request-to-send.
        n_err = 0;
        start_tx(8'hFF);
        wait_inhibit(cnt);
        t = 0;
        while (!tx_error && t < 3000) begin
            tick();
            t++;
        end
        check("timeout_cycles", t, 2000);
        check("timeout_released", {ps2clk_oe, ps2data_oe}, 0);
        tick();
        check("timeout_pulse_width", tx_error, 0);
        ticks(10);

        // Reset in the middle of the data phase, after four device clocks.
        start_tx(8'hA5);
        wait_inhibit(cnt);
        ticks(30);
        for (int k = 0; k < 4; k++) begin
            dev_clk_low = 1'b1;
            ticks(60);
            dev_clk_low = 1'b0;
            ticks(30);
        end
        n_done = 0;
        n_err = 0;
        reset = 1'b1;
        tick();
        check("midrst_lines", {ps2clk_oe, ps2data_oe}, 0);
        check("midrst_ready", tx_ready, 1);
        check("midrst_busy", tx_busy, 0);
        reset = 1'b0;
        ticks(20);
        check("midrst_no_pulse", n_done + n_err, 0);
        run_xfer('{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
